// File: rtl/r2fft_sequencer_if.sv
// Control bundle between the radix-2 FFT phase sequencer and its surroundings:
// stream I/O wrappers, butterfly pipeline and sample RAM ports.
interface r2fft_sequencer_if #(
  parameter int FFT_LENGTH_LOG2 = 10
);
  localparam int L  = FFT_LENGTH_LOG2;
  localparam int SW = (L > 1) ? $clog2(L) : 1;

  logic          start;
  logic          sampleValid;
  logic          ldWe;
  logic [L-1:0]  ldAddr;
  logic          bfIssue;
  logic [L-1:0]  bfAddrA;
  logic [L-1:0]  bfAddrB;
  logic [L-2:0]  bfTwiddle;
  logic [SW-1:0] stage;
  logic          outReady;
  logic          rdEn;
  logic [L-1:0]  rdAddr;
  logic          busy;
  logic          done;

  modport master (
    input  start, sampleValid, outReady,
    output ldWe, ldAddr, bfIssue, bfAddrA, bfAddrB, bfTwiddle, stage,
           rdEn, rdAddr, busy, done
  );

  modport slave (
    output start, sampleValid, outReady,
    input  ldWe, ldAddr, bfIssue, bfAddrA, bfAddrB, bfTwiddle, stage,
           rdEn, rdAddr, busy, done
  );
endinterface

// File: rtl/r2fft_sequencer.sv
// Phase controller for the in-place radix-2 DIT FFT: bit-reversed LOAD,
// log2(N) stages of butterfly issue with drain gaps, natural-order UNLOAD.
module r2fft_sequencer #(
  parameter int FFT_LENGTH_LOG2   = 10,
  parameter int BUTTERFLY_LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  r2fft_sequencer_if.master   bus
);
  localparam int L  = FFT_LENGTH_LOG2;
  localparam int SW = (L > 1) ? $clog2(L) : 1;
  localparam int DW = (BUTTERFLY_LATENCY > 1) ? $clog2(BUTTERFLY_LATENCY) : 1;

  localparam logic [L-1:0]  LAST_SAMPLE = {L{1'b1}};
  localparam logic [L-1:0]  LAST_BFLY   = {1'b0, {(L-1){1'b1}}};
  localparam logic [SW-1:0] LAST_STAGE  = SW'(L - 1);
  localparam logic [DW-1:0] LAST_DRAIN  = DW'(BUTTERFLY_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DRAIN,
    S_UNLOAD
  } state_t;

  state_t        state_q, state_d;
  logic [L-1:0]  cnt_q, cnt_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [DW-1:0] dly_q, dly_d;

  logic          bf_issue_q, bf_issue_d;
  logic [L-1:0]  bf_a_q, bf_a_d;
  logic [L-1:0]  bf_b_q, bf_b_d;
  logic [L-2:0]  bf_tw_q, bf_tw_d;

  logic          ld_we, rd_en, done_c;
  logic [L-1:0]  ld_addr, rd_addr;

  function automatic logic [L-1:0] bit_rev(input logic [L-1:0] v);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[i] = v[L-1-i];
    return r;
  endfunction

  // Upper leg: group base (grp * 2h) plus position inside the group.
  function automatic logic [L-1:0] bf_addr_a(input logic [L-2:0] j,
                                             input logic [SW-1:0] s);
    logic [L-1:0] jj, pos, grp;
    jj  = {1'b0, j};
    pos = jj & ((L'(1) << s) - L'(1));
    grp = jj >> s;
    return (grp << s << 1) | pos;
  endfunction

  function automatic logic [L-2:0] bf_twiddle(input logic [L-2:0] j,
                                              input logic [SW-1:0] s);
    logic [L-2:0] pos;
    pos = j & (((L-1)'(1) << s) - (L-1)'(1));
    return pos << (LAST_STAGE - s);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    dly_d   = dly_q;
    ld_we   = 1'b0;
    ld_addr = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
    done_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      S_LOAD: begin
        ld_we   = bus.sampleValid;
        ld_addr = bit_rev(cnt_q);
        if (bus.sampleValid) begin
          cnt_d = cnt_q + L'(1);
          if (cnt_q == LAST_SAMPLE) state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q == LAST_BFLY) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          dly_d   = '0;
        end else begin
          cnt_d = cnt_q + L'(1);
        end
      end
      S_DRAIN: begin
        // Hold off the next stage until the last write-back has landed.
        if (dly_q == LAST_DRAIN) begin
          if (stage_q == LAST_STAGE) begin
            state_d = S_UNLOAD;
          end else begin
            state_d = S_CALC;
            stage_d = stage_q + SW'(1);
          end
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      S_UNLOAD: begin
        rd_en   = bus.outReady;
        rd_addr = cnt_q;
        if (bus.outReady) begin
          cnt_d = cnt_q + L'(1);
          if (cnt_q == LAST_SAMPLE) begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Butterfly outputs are registered, so they are computed from next state.
    bf_issue_d = (state_d == S_CALC);
    bf_a_d     = '0;
    bf_b_d     = '0;
    bf_tw_d    = '0;
    if (bf_issue_d) begin
      bf_a_d  = bf_addr_a(cnt_d[L-2:0], stage_d);
      bf_b_d  = bf_a_d + (L'(1) << stage_d);
      bf_tw_d = bf_twiddle(cnt_d[L-2:0], stage_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      stage_q    <= '0;
      dly_q      <= '0;
      bf_issue_q <= 1'b0;
      bf_a_q     <= '0;
      bf_b_q     <= '0;
      bf_tw_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      dly_q      <= dly_d;
      bf_issue_q <= bf_issue_d;
      bf_a_q     <= bf_a_d;
      bf_b_q     <= bf_b_d;
      bf_tw_q    <= bf_tw_d;
    end
  end

  assign bus.ldWe      = ld_we;
  assign bus.ldAddr    = ld_addr;
  assign bus.bfIssue   = bf_issue_q;
  assign bus.bfAddrA   = bf_a_q;
  assign bus.bfAddrB   = bf_b_q;
  assign bus.bfTwiddle = bf_tw_q;
  assign bus.stage     = stage_q;
  assign bus.rdEn      = rd_en;
  assign bus.rdAddr    = rd_addr;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_c;

endmodule

// File: tb/tb_r2fft_sequencer.sv
// Scoreboard bench for r2fft_sequencer at N=16, butterfly latency 4.
module tb_r2fft_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  r2fft_sequencer_if #(.FFT_LENGTH_LOG2(4)) bus ();

  r2fft_sequencer #(.FFT_LENGTH_LOG2(4), .BUTTERFLY_LATENCY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int a; int b; int tw; int st; } bf_t;
  typedef struct { int addr; int dn; } rd_t;

  int  ld_q[$];
  bf_t bf_q[$];
  rd_t rd_q[$];

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b0;

  int LD_TAB [16]   = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int A_TAB  [4][8] = '{'{0, 2, 4, 6, 8, 10, 12, 14},
                        '{0, 1, 4, 5, 8, 9, 12, 13},
                        '{0, 1, 2, 3, 8, 9, 10, 11},
                        '{0, 1, 2, 3, 4, 5, 6, 7}};
  int B_TAB  [4][8] = '{'{1, 3, 5, 7, 9, 11, 13, 15},
                        '{2, 3, 6, 7, 10, 11, 14, 15},
                        '{4, 5, 6, 7, 12, 13, 14, 15},
                        '{8, 9, 10, 11, 12, 13, 14, 15}};
  int TW_TAB [4][8] = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                        '{0, 4, 0, 4, 0, 4, 0, 4},
                        '{0, 2, 4, 6, 0, 2, 4, 6},
                        '{0, 1, 2, 3, 4, 5, 6, 7}};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ld(input int n);
    for (int i = 0; i < n; i++) ld_q.push_back(LD_TAB[i]);
  endtask

  task automatic push_bf();
    bf_t e;
    for (int s = 0; s < 4; s++)
      for (int j = 0; j < 8; j++) begin
        e.a = A_TAB[s][j]; e.b = B_TAB[s][j]; e.tw = TW_TAB[s][j]; e.st = s;
        bf_q.push_back(e);
      end
  endtask

  task automatic push_rd();
    rd_t e;
    for (int i = 0; i < 16; i++) begin
      e.addr = i; e.dn = (i == 15) ? 1 : 0;
      rd_q.push_back(e);
    end
  endtask

  task automatic do_load(input int gap);
    for (int i = 0; i < 16; i++) begin
      bus.sampleValid = 1'b1;
      step();
      bus.sampleValid = 1'b0;
      if (i != 15) repeat (gap) step();
    end
  endtask

  // Expect 4 stages of 8 issue cycles, each followed by 4 idle drain cycles.
  task automatic calc_window(input bit poke);
    for (int k = 0; k < 48; k++) begin
      chk($sformatf("calc_issue_%0d", k), int'(bus.bfIssue), ((k % 12) < 8) ? 1 : 0);
      chk($sformatf("calc_stage_%0d", k), int'(bus.stage), k / 12);
      if (poke && k >= 2 && k <= 4) begin
        bus.start = 1'b1; bus.sampleValid = 1'b1; bus.outReady = 1'b1;
      end else begin
        bus.start = 1'b0; bus.sampleValid = 1'b0; bus.outReady = 1'b0;
      end
      step();
    end
    chk("unload_issue", int'(bus.bfIssue), 0);
    chk("unload_busy", int'(bus.busy), 1);
  endtask

  task automatic unload(input bit toggle);
    int n;
    n = toggle ? 31 : 16;
    for (int c = 0; c < n; c++) begin
      bus.outReady = toggle ? ((c % 2) == 0) : 1'b1;
      step();
    end
    bus.outReady = 1'b0;
    chk("busy_after_done", int'(bus.busy), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.ldWe) begin
        if (ld_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ld_extra actual=ldAddr %0d required=no write", bus.ldAddr);
        end else chk("ldAddr", int'(bus.ldAddr), ld_q.pop_front());
      end
      if (bus.bfIssue) begin
        if (bf_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bf_extra actual=A %0d required=no issue", bus.bfAddrA);
        end else begin
          bf_t e;
          e = bf_q.pop_front();
          chk("bfAddrA", int'(bus.bfAddrA), e.a);
          chk("bfAddrB", int'(bus.bfAddrB), e.b);
          chk("bfTwiddle", int'(bus.bfTwiddle), e.tw);
          chk("bfStage", int'(bus.stage), e.st);
        end
      end
      if (bus.rdEn) begin
        if (rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_extra actual=rdAddr %0d required=no read", bus.rdAddr);
        end else begin
          rd_t e;
          e = rd_q.pop_front();
          chk("rdAddr", int'(bus.rdAddr), e.addr);
          chk("rd_done", int'(bus.done), e.dn);
        end
      end
      if (bus.done) begin
        done_cnt++;
        if (!bus.rdEn) begin
          checks++; failures++;
          $display("FAIL done_without_read actual=done 1 required=0");
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.sampleValid = 1'b0; bus.outReady = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (5) step();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_bfIssue", int'(bus.bfIssue), 0);
    chk("rst_ldAddr", int'(bus.ldAddr), 0);
    chk("rst_bfAddrA", int'(bus.bfAddrA), 0);
    chk("rst_bfAddrB", int'(bus.bfAddrB), 0);
    chk("rst_rdAddr", int'(bus.rdAddr), 0);
    chk("rst_stage", int'(bus.stage), 0);

    // Phase inputs in IDLE are ignored.
    bus.outReady = 1'b1; bus.sampleValid = 1'b1;
    #1;
    chk("idle_rdEn", int'(bus.rdEn), 0);
    chk("idle_ldWe", int'(bus.ldWe), 0);
    step();
    bus.outReady = 1'b0; bus.sampleValid = 1'b0;
    chk("idle_stay", int'(bus.busy), 0);

    // Contiguous load, full calc, toggled unload.
    push_ld(16); push_bf(); push_rd();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("load_busy", int'(bus.busy), 1);
    do_load(0);
    calc_window(1'b0);
    unload(1'b1);
    chk("done_cnt_1", done_cnt, 1);

    // start/sampleValid/outReady poked during CALC are ignored.
    push_ld(16); push_bf(); push_rd();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    do_load(0);
    calc_window(1'b1);
    unload(1'b0);
    chk("done_cnt_2", done_cnt, 2);

    // Abort mid-LOAD after 5 samples.
    push_ld(5);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    repeat (5) begin
      bus.sampleValid = 1'b1; step();
    end
    bus.sampleValid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    step();
    chk("abort_idle", int'(bus.busy), 0);
    chk("abort_no_done", done_cnt, 2);
    chk("abort_ld_consumed", ld_q.size(), 0);

    // Reload from address 0 with sparse samples.
    push_ld(16); push_bf(); push_rd();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    do_load(2);
    calc_window(1'b0);
    unload(1'b0);
    chk("done_cnt_3", done_cnt, 3);

    chk("ld_q_left", ld_q.size(), 0);
    chk("bf_q_left", bf_q.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
